fp_addsub_sched: RTL

//  Round-robin scheduler sharing one pipelined FP32 add/sub core among NUM_REQ requesters.

---
 rtl/fp_addsub_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: round-robin scheduler sharing one pipelined FP32 add/sub core (FP_SCHED_STATS_EN adds stat counters)
module fp_addsub_sched #(
  parameter int NUM_REQ = 4,
  parameter int CORE_LAT = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_a,
  input  logic [32*NUM_REQ-1:0]      req_b,
  input  logic [NUM_REQ-1:0]         req_op,
  output logic                       core_valid,
  output logic [31:0]                core_a,
  output logic [31:0]                core_b,
  output logic                       core_op,
  input  logic                       core_res_valid,
  input  logic [31:0]                core_res,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  input  logic                       flush_req,
  output logic                       flush_done
`ifdef FP_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, win, idx;
  logic any, grant, blk, pop_tag, pop_rsp, tag_empty;
  logic [CW-1:0] inflight, tag_wr, tag_rd, res_wr, res_rd;
  logic [IW-1:0] tag_mem [MAX_INFLIGHT];
  logic [IW+31:0] res_mem [MAX_INFLIGHT];
  logic [CORE_LAT-1:0] exp_ret;
  assign tag_empty = tag_wr == tag_rd;
  assign pop_tag = core_res_valid && !tag_empty;
  assign rsp_valid = res_wr != res_rd;
  assign pop_rsp = rsp_valid && rsp_ready;
  assign {rsp_id, rsp_data} = rsp_valid ? res_mem[res_rd[AW-1:0]] : '0;
  assign flush_done = state == DONE;
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    grant = any && !rst && (state == IDLE || state == RUN) && inflight < CW'(MAX_INFLIGHT);
    req_ready = grant ? NUM_REQ'(1) << win : '0;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, RUN: state_n = (flush_req && !blk) ? DRAIN : (|req_valid || inflight != '0) ? RUN : IDLE;
      DRAIN:     state_n = inflight == '0 ? DONE : DRAIN;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      blk <= 1'b0;
      inflight <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      res_wr <= '0;
      res_rd <= '0;
      core_valid <= 1'b0;
      core_a <= '0;
      core_b <= '0;
      core_op <= 1'b0;
      exp_ret <= '0;
    end else begin
      state <= state_n;
      blk <= state == DONE || (blk && flush_req);
      inflight <= inflight + CW'(grant) - CW'(pop_rsp);
      core_valid <= grant;
      exp_ret <= CORE_LAT'({exp_ret, core_valid});
      if (grant) begin
        ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        core_a <= req_a[{win, 5'd0} +: 32];
        core_b <= req_b[{win, 5'd0} +: 32];
        core_op <= req_op[win];
        tag_wr <= tag_wr + 1'b1;
      end
      if (pop_tag) begin
        tag_rd <= tag_rd + 1'b1;
        res_wr <= res_wr + 1'b1;
      end
      if (pop_rsp) res_rd <= res_rd + 1'b1;
    end
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr[AW-1:0]] <= win;
    if (pop_tag) res_mem[res_wr[AW-1:0]] <= {tag_mem[tag_rd[AW-1:0]], core_res};
  end
  a_core_ret: assert property (@(posedge clk) disable iff (rst) core_res_valid |-> !tag_empty && exp_ret[CORE_LAT-1]);
`ifdef FP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_issued <= '0;
      stat_stall <= '0;
    end else begin
      if (grant && !(&stat_issued)) stat_issued <= stat_issued + 1'b1;
      if (|req_valid && !grant && !(&stat_stall)) stat_stall <= stat_stall + 1'b1;
    end
`endif
endmodule
